// File: rtl/bcd_counter10.sv
// Single-digit BCD up/down counter with a 2-flop step synchroniser and rising-edge detector.
// It has a synchronous active-low reset, and clear/load take priority over counting.
module bcd_counter10 #(
  parameter bit AUTO_WRAP = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       step_in,
  input  logic       up_dn,
  input  logic       cnt_en,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clr,
  output logic [3:0] bcd_out,
  output logic       bcd_vld,
  output logic       carry,
  output logic       borrow,
  output logic       err
);

  logic       s1_q, s2_q, s3_q;
  logic [3:0] cnt_q, cnt_d;
  logic       vld_q;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;
  logic       err_q, err_d;
  logic       step_edge;

  assign step_edge = s2_q & ~s3_q;

  always_comb begin
    cnt_d    = cnt_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    err_d    = 1'b0;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (load) begin
      if (load_val <= 4'd9) begin
        cnt_d = load_val;
      end else begin
        err_d = 1'b1;
      end
    end else if (step_edge && cnt_en) begin
      if (up_dn) begin
        if (cnt_q == 4'd9) begin
          if (AUTO_WRAP) begin
            cnt_d   = 4'd0;
            carry_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        if (cnt_q == 4'd0) begin
          if (AUTO_WRAP) begin
            cnt_d    = 4'd9;
            borrow_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    end
  end

  // Synchroniser flops reset high so a step held across reset release is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_q     <= 1'b1;
      s2_q     <= 1'b1;
      s3_q     <= 1'b1;
      cnt_q    <= 4'd0;
      vld_q    <= 1'b0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s1_q     <= step_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      vld_q    <= 1'b1;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      err_q    <= err_d;
    end
  end

  assign bcd_out = cnt_q;
  assign bcd_vld = vld_q;
  assign carry   = carry_q;
  assign borrow  = borrow_q;
  assign err     = err_q;

endmodule

// File: tb/tb_bcd_counter10.sv
// Bench for bcd_counter10: a wrapping and a saturating instance share stimulus and are
// checked every cycle against a timestamp-queue reference model, plus table and directed cases.
module tb_bcd_counter10;

  logic       clk = 1'b0;
  logic       rstn, step_in, up_dn, cnt_en, load, clr;
  logic [3:0] load_val;
  logic [3:0] bcd_a, bcd_s;
  logic       vld_a, vld_s, carry_a, carry_s, borrow_a, borrow_s, err_a, err_s;

  int n_tests = 0;
  int n_fail  = 0;
  int carry_seen = 0;

  always #5 clk = ~clk;

  bcd_counter10 #(.AUTO_WRAP(1'b1)) u_wrap (
    .clk(clk), .rstn(rstn), .step_in(step_in), .up_dn(up_dn), .cnt_en(cnt_en),
    .load(load), .load_val(load_val), .clr(clr), .bcd_out(bcd_a), .bcd_vld(vld_a),
    .carry(carry_a), .borrow(borrow_a), .err(err_a)
  );

  bcd_counter10 #(.AUTO_WRAP(1'b0)) u_sat (
    .clk(clk), .rstn(rstn), .step_in(step_in), .up_dn(up_dn), .cnt_en(cnt_en),
    .load(load), .load_val(load_val), .clr(clr), .bcd_out(bcd_s), .bcd_vld(vld_s),
    .carry(carry_s), .borrow(borrow_s), .err(err_s)
  );

  // Reference model: index 0 wraps, index 1 saturates. A fresh rising sample of step_in
  // at edge n schedules a count for edge n+2; reset drops anything scheduled.
  int m_cnt [2];
  bit m_carry [2];
  bit m_borrow [2];
  bit m_vld = 1'b0;
  bit m_err = 1'b0;
  int cyc = 0;
  int due_q [$];
  bit last_samp = 1'b1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit ev;
    int nxt;
    if (!rstn) begin
      for (int w = 0; w < 2; w++) begin
        m_cnt[w] = 0; m_carry[w] = 0; m_borrow[w] = 0;
      end
      m_vld = 0; m_err = 0;
      due_q.delete();
      last_samp = 1'b1;
    end else begin
      ev = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        ev = 1'b1;
      end
      m_vld = 1; m_err = 0;
      for (int w = 0; w < 2; w++) begin
        m_carry[w] = 0; m_borrow[w] = 0;
      end
      if (clr) begin
        m_cnt[0] = 0; m_cnt[1] = 0;
      end else if (load) begin
        if (int'(load_val) <= 9) begin
          m_cnt[0] = int'(load_val); m_cnt[1] = int'(load_val);
        end else begin
          m_err = 1;
        end
      end else if (ev && cnt_en) begin
        for (int w = 0; w < 2; w++) begin
          nxt = m_cnt[w] + (up_dn ? 1 : -1);
          if (nxt >= 0 && nxt <= 9) m_cnt[w] = nxt;
          else if (w == 0) begin
            m_cnt[w] = (nxt + 10) % 10;
            if (up_dn) m_carry[w] = 1; else m_borrow[w] = 1;
          end
        end
      end
      if (step_in && !last_samp) due_q.push_back(cyc + 2);
      last_samp = step_in;
    end
    cyc++;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    carry_seen += int'(carry_a);
    check("model_wrap", {bcd_a, vld_a, carry_a, borrow_a, err_a},
          {4'(m_cnt[0]), m_vld, m_carry[0], m_borrow[0], m_err});
    check("model_sat", {bcd_s, vld_s, carry_s, borrow_s, err_s},
          {4'(m_cnt[1]), m_vld, m_carry[1], m_borrow[1], m_err});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    logic       clr;
    logic       load;
    logic [3:0] val;
    logic [3:0] exp_bcd;
    logic       exp_err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int changes;
    logic [3:0] prev;

    vecs[0]  = '{1'b0, 1'b1, 4'd7,  4'd7, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd12, 4'd7, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 4'd15, 4'd7, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 4'd9,  4'd9, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'd10, 4'd9, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 4'd3,  4'd0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'd12, 4'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'd0,  4'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 4'd5,  4'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 4'd4,  4'd4, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 4'd8,  4'd0, 1'b0};

    rstn = 0; step_in = 0; up_dn = 1; cnt_en = 1; load = 0; clr = 0; load_val = 0;
    cycles(3);
    check("reset_bcd", {bcd_a, vld_a}, 5'h00);
    rstn = 1;
    cycle();
    check("vld_after_reset", {bcd_a, vld_a}, 5'h01);

    // Twelve clean up-steps: wrap instance goes 1..9,0,1,2; saturating one sticks at 9.
    carry_seen = 0;
    for (int k = 1; k <= 12; k++) begin
      step_in = 1;
      cycles(3);
      check("up_wrap", bcd_a, 8'(k % 10));
      check("up_sat", bcd_s, 8'((k > 9) ? 9 : k));
      check("carry_at_wrap", carry_a, (k == 10));
      step_in = 0;
      cycles(2);
    end
    check("carry_count", 8'(carry_seen), 8'd1);

    // Down from 0: wrap borrows to 9, saturating holds 0.
    load = 1; load_val = 0; cycle(); load = 0;
    up_dn = 0; step_in = 1;
    cycles(3);
    check("borrow_wrap", {bcd_a, borrow_a}, {4'd9, 1'b1});
    check("borrow_sat", {bcd_s, borrow_s}, {4'd0, 1'b0});
    step_in = 0;
    cycles(2);
    check("borrow_one_cycle", borrow_a, 1'b0);

    for (int i = 0; i < 11; i++) begin
      clr = vecs[i].clr; load = vecs[i].load; load_val = vecs[i].val;
      cycle();
      check($sformatf("vec%0d_wrap", i), {bcd_a, err_a}, {vecs[i].exp_bcd, vecs[i].exp_err});
      check($sformatf("vec%0d_sat", i), {bcd_s, err_s}, {vecs[i].exp_bcd, vecs[i].exp_err});
    end
    clr = 0; load = 0;
    load_val = 12; load = 1; cycle(); load = 0;
    cycle();
    check("err_one_cycle", err_a, 1'b0);

    // Clear, load and count edge all in one cycle.
    up_dn = 1;
    load = 1; load_val = 5; cycle(); load = 0;
    step_in = 1; cycles(2);
    clr = 1; load = 1; load_val = 4; cycle();
    check("clr_wins", bcd_a, 8'd0);
    clr = 0; load = 0; step_in = 0; cycles(3);
    check("edge_not_queued", bcd_a, 8'd0);
    step_in = 1; cycles(2);
    load = 1; load_val = 4; cycle();
    check("load_wins", bcd_a, 8'd4);
    load = 0; step_in = 0; cycles(3);
    check("load_no_extra", bcd_a, 8'd4);

    // Held step counts once, at the third sampling edge.
    changes = 0; prev = bcd_a;
    step_in = 1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bcd_a !== prev) changes++;
      if (i == 2) check("held_third_edge", bcd_a, 8'd5);
      prev = bcd_a;
    end
    check("held_single", 8'(changes), 8'd1);
    step_in = 0; cycles(2);
    cnt_en = 0; step_in = 1; cycles(3);
    check("cnt_en_low", bcd_a, 8'd5);
    cnt_en = 1; step_in = 0; cycles(3);
    check("cnt_en_no_late", bcd_a, 8'd5);

    // Step held high across reset release must not count.
    step_in = 1; rstn = 0; cycles(2);
    rstn = 1; cycle();
    check("held_reset_release", {bcd_a, vld_a}, {4'd0, 1'b1});
    cycles(5);
    check("held_reset_nocount", bcd_a, 8'd0);
    step_in = 0; cycle();
    step_in = 1; cycles(3);
    check("fresh_edge_counts", bcd_a, 8'd1);

    // Edge in flight when reset hits is abandoned.
    step_in = 0; cycles(2);
    step_in = 1; cycle();
    rstn = 0; cycle();
    rstn = 1; step_in = 0; cycles(4);
    check("inflight_dropped", {bcd_a, carry_a}, 5'h00);

    for (int i = 0; i < 800; i++) begin
      rstn     = ($urandom_range(0, 59) != 0);
      clr      = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 13) == 0);
      load_val = 4'($urandom_range(0, 15));
      up_dn    = ($urandom_range(0, 2) != 0);
      cnt_en   = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 2) == 0) step_in = ~step_in;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
